// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared widths and limits for the countdown timer datapath
package timer_pkg;

  localparam int MS_W  = 10;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam int MS_MAX  = 999;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  // Number of enabled clocks per 1 ms tick.
  function automatic int ms_divisor(input int clk_freq_hz);
    return clk_freq_hz / 1000;
  endfunction

endpackage

// File: rtl/timer_countdown_datapath_if.sv
// rtl/timer_countdown_datapath_if.sv - control/status bundle between timer FSM and datapath
interface timer_countdown_datapath_if;
  import timer_pkg::*;

  logic             i_clk_en;
  logic             i_clr;
  logic             i_ms_up;
  logic             i_ms_down;
  logic             i_sec_up;
  logic             i_sec_down;
  logic             i_min_up;
  logic             i_min_down;
  logic             i_hr_up;
  logic             i_hr_down;
  logic             o_ms_pulse;
  logic             o_ms_borrowdown;
  logic             o_sec_borrowdown;
  logic             o_min_borrowdown;
  logic [MS_W-1:0]  o_ms;
  logic [SEC_W-1:0] o_sec;
  logic [MIN_W-1:0] o_min;
  logic [HR_W-1:0]  o_hr;

  // Control FSM side.
  modport master (
    output i_clk_en, i_clr, i_ms_up, i_ms_down, i_sec_up, i_sec_down,
           i_min_up, i_min_down, i_hr_up, i_hr_down,
    input  o_ms_pulse, o_ms_borrowdown, o_sec_borrowdown, o_min_borrowdown,
           o_ms, o_sec, o_min, o_hr
  );

  // Datapath side.
  modport slave (
    input  i_clk_en, i_clr, i_ms_up, i_ms_down, i_sec_up, i_sec_down,
           i_min_up, i_min_down, i_hr_up, i_hr_down,
    output o_ms_pulse, o_ms_borrowdown, o_sec_borrowdown, o_min_borrowdown,
           o_ms, o_sec, o_min, o_hr
  );

endinterface

// File: rtl/timer_field_counter.sv
// rtl/timer_field_counter.sv - wrapping up/down counter for one time field
module timer_field_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         clr,
  input  logic         en_up,
  input  logic         en_down,
  output logic [W-1:0] value,
  output logic         is_zero
);

  // Step by one with wrap at 0/MAX; clear wins, simultaneous up and down hold.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en_up && !en_down) begin
      value <= (value == W'(MAX)) ? '0 : value + 1'b1;
    end else if (en_down && !en_up) begin
      value <= (value == '0) ? W'(MAX) : value - 1'b1;
    end
  end

  assign is_zero = (value == '0);

endmodule

// File: rtl/timer_countdown_datapath.sv
// rtl/timer_countdown_datapath.sv - hr:min:sec:ms counters, 1 ms prescaler and borrow flags
module timer_countdown_datapath
  import timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int HR_MAX      = 23
) (
  input logic                          i_clk,
  input logic                          i_rstn,
  timer_countdown_datapath_if.slave    bus
);

  localparam int DIV = ms_divisor(CLK_FREQ_HZ);
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  logic [PW-1:0] presc_cnt;
  logic          tick;
  logic          ms_zero;
  logic          sec_zero;
  logic          min_zero;
  logic          hr_zero;

  // Prescaler: free-runs 0..DIV-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      presc_cnt <= '0;
    end else if (bus.i_clr || !bus.i_clk_en || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  assign tick = bus.i_clk_en && (presc_cnt == TERM);

  timer_field_counter #(.W(MS_W), .MAX(MS_MAX)) u_ms (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .clr     (bus.i_clr),
    .en_up   (tick && bus.i_ms_up),
    .en_down (tick && bus.i_ms_down),
    .value   (bus.o_ms),
    .is_zero (ms_zero)
  );

  timer_field_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .clr     (bus.i_clr),
    .en_up   (bus.i_sec_up),
    .en_down (bus.i_sec_down),
    .value   (bus.o_sec),
    .is_zero (sec_zero)
  );

  timer_field_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .clr     (bus.i_clr),
    .en_up   (bus.i_min_up),
    .en_down (bus.i_min_down),
    .value   (bus.o_min),
    .is_zero (min_zero)
  );

  timer_field_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .clr     (bus.i_clr),
    .en_up   (bus.i_hr_up),
    .en_down (bus.i_hr_down),
    .value   (bus.o_hr),
    .is_zero (hr_zero)
  );

  // The hr field never borrows; its zero flag is only kept for symmetry.
  logic unused_hr_zero;
  assign unused_hr_zero = hr_zero;

  // Borrow flags are same-cycle so the FSM can ripple ms->sec->min->hr in one clock.
  assign bus.o_ms_pulse       = tick;
  assign bus.o_ms_borrowdown  = tick && bus.i_ms_down && ms_zero;
  assign bus.o_sec_borrowdown = bus.i_sec_down && sec_zero;
  assign bus.o_min_borrowdown = bus.i_min_down && min_zero;

endmodule
